// File: rtl/pc_ir.sv
// Program counter and instruction register stage: PC sequencing, IR capture,
// sticky fetch breakpoint and saturating instruction/branch counters.
module pc_ir #(
  parameter int AW = 16,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    ps_in,
  input  logic          il_in,
  input  logic [15:0]   mem_data_in,
  input  logic [AW-1:0] ra_in,
  input  logic          bp_en_in,
  input  logic [AW-1:0] bp_addr_in,
  input  logic          bp_clr_in,
  input  logic          ctr_clr_in,
  output logic [15:0]   ins_out,
  output logic [AW-1:0] pc_out,
  output logic          bp_hit_out,
  output logic [CW-1:0] icount_out,
  output logic [CW-1:0] brcount_out
);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  logic [AW-1:0] pc_reg, pc_next;
  logic [15:0]   ir_reg, ir_next;
  logic          bp_reg, bp_next;
  logic [CW-1:0] icount_reg, icount_next;
  logic [CW-1:0] brcount_reg, brcount_next;

  // Branch offset always comes from the registered IR, even when a new word loads this cycle.
  logic [5:0]    br_off;
  logic [AW-1:0] br_off_ext;
  logic          is_branch;
  logic          bp_match;

  assign br_off     = {ir_reg[8:6], ir_reg[2:0]};
  assign br_off_ext = {{(AW-6){br_off[5]}}, br_off};
  assign is_branch  = (ps_in == PS_BR) || (ps_in == PS_JMP);
  assign bp_match   = il_in && bp_en_in && (pc_reg == bp_addr_in);

  always_comb begin
    pc_next = pc_reg;
    case (ps_in)
      PS_HOLD: pc_next = pc_reg;
      PS_INC:  pc_next = pc_reg + AW'(1);
      PS_BR:   pc_next = pc_reg + br_off_ext;
      PS_JMP:  pc_next = ra_in;
      default: pc_next = pc_reg;
    endcase
  end

  always_comb begin
    ir_next      = il_in ? mem_data_in : ir_reg;
    icount_next  = icount_reg;
    brcount_next = brcount_reg;
    if (ctr_clr_in) begin
      icount_next  = '0;
      brcount_next = '0;
    end else begin
      if (il_in && !(&icount_reg))
        icount_next = icount_reg + CW'(1);
      if (is_branch && !(&brcount_reg))
        brcount_next = brcount_reg + CW'(1);
    end
  end

  // A new hit outranks a clear in the same cycle.
  always_comb begin
    bp_next = bp_reg;
    if (bp_match)
      bp_next = 1'b1;
    else if (bp_clr_in)
      bp_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= '0;
      ir_reg      <= 16'h0000;
      bp_reg      <= 1'b0;
      icount_reg  <= '0;
      brcount_reg <= '0;
    end else begin
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      bp_reg      <= bp_next;
      icount_reg  <= icount_next;
      brcount_reg <= brcount_next;
    end
  end

  assign pc_out      = pc_reg;
  assign ins_out     = ir_reg;
  assign bp_hit_out  = bp_reg;
  assign icount_out  = icount_reg;
  assign brcount_out = brcount_reg;

endmodule

// File: doc/pc_ir.md
# pc_ir

Program-counter and instruction-register stage of the mycpu core, directly upstream of the control unit. Holds the program counter (PC) and drives it as the fetch address. Captures the fetched instruction word and feeds it to the control unit's instruction input. Executes the control unit's PC-select (`ps`) and instruction-load (`il`) commands, and also provides a hardware breakpoint and saturating instruction and branch counters for debug.

## Interface
- `AW`, 16: PC width in bits.
- `CW`, 32: width of both performance counters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ps_in`  in  2  PC select from the control unit:
  - 00 = hold
  - 01 = increment
  - 10 = relative branch
  - 11 = jump to register A
- `il_in`  in  1  instruction load: IR <= `mem_data_in`.
- `mem_data_in`  in  16  instruction word read from memory at `pc_out`.
- `ra_in`  in  AW  register-file A bus; the jump target.
- `bp_en_in`  in  1  breakpoint enable.
- `bp_addr_in`  in  AW  breakpoint address.
- `bp_clr_in`  in  1  clears a sticky `bp_hit_out`.
- `ctr_clr_in`  in  1  synchronous clear of both counters.
- `ins_out`  out  16  IR contents; feeds the control unit instruction input.
- `pc_out`  out  AW  current PC; the fetch address.
- `bp_hit_out`  out  1  sticky breakpoint flag.
- `icount_out`  out  CW  instructions loaded, saturating.
- `brcount_out`  out  CW  taken branches and jumps, saturating.

## Operation
- Reset values: PC = 0, IR = 16'h0000 (opcode 0, a harmless MOVA R0), `bp_hit_out` = 0, both counters = 0.
- PC update on each edge, all arithmetic modulo 2^AW:
  - 00: PC unchanged.
  - 01: PC <= PC + 1.
  - 10: PC <= PC + sext({IR[8:6], IR[2:0]}). The offset is 6-bit two's complement, range −32..+31, sign-extended to AW. It is relative to the PC of the branch instruction itself, because PC is not advanced during fetch.
  - 11: PC <= `ra_in`.
- The branch offset is always taken from the registered IR, never from `mem_data_in`.
- IR: when `il_in` = 1, IR <= `mem_data_in`; otherwise IR holds.
- `il_in` and `ps_in` act independently. If both are active in the same cycle, both updates apply, and the branch offset uses the old IR.
- `icount_out` increments on every cycle with `il_in` = 1.
- `brcount_out` increments on every cycle with `ps_in` = 10 or 11. The control unit drives 10 only when a branch is taken, so not-taken branches are not counted.
- Both counters saturate at all-ones and never wrap.
- `ctr_clr_in` clears both counters and takes priority over any increment in the same cycle.
- Breakpoint: on a cycle with `il_in` = 1, `bp_en_in` = 1 and `pc_out` == `bp_addr_in`, `bp_hit_out` is set on that edge.
  - The flag stays set until a cycle with `bp_clr_in` = 1.
  - If set and clear occur in the same cycle, set wins.
  - The block does not stall anything; the debug wrapper consumes `bp_hit_out`.
- Reset asserted mid-operation forces all state to its reset values immediately. The first fetch after reset is from address 0.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `pc_out` changes one edge after `ps_in` is sampled.
- `ins_out` is valid one edge after `il_in`, i.e. during the control unit's EX0 cycle.
- `mem_data_in` must be stable at the edge where `il_in` = 1. Memory is asynchronous-read on `pc_out` in the same cycle.
- Counters and `bp_hit_out` update on the same edge as the event that causes them.
- Nominal instruction cadence: INF (`il`=1, `ps`=00) then EX0 (`ps`≠00). One instruction per two cycles.

## Test plan
- Reset, then INF/EX0 pairs with `ps`=01 over memory words 0..3: `pc_out` steps 0,0,1,1,2,2,3; `ins_out` equals each word one cycle after its INF; `icount_out` = 4.
- PC = 5, IR offset bits {IR[8:6], IR[2:0]} = 6'b111110 (−2), `ps`=10: PC = 3; `brcount_out` increments by 1.
- PC = 1, offset −4, AW=16, `ps`=10: PC = 16'hFFFD (wrap). Then `ps`=01 three times: PC = 0.
- `ra_in` = 16'h1234, `ps`=11 together with `il_in`=1: PC = 16'h1234; IR loads the new word; `brcount_out` increments.
- `bp_en_in`=1, `bp_addr_in`=2, run sequential fetch: `bp_hit_out` rises on the edge of the fetch at PC=2 and stays set. `bp_clr_in` clears it. `bp_clr_in` asserted together with a new hit keeps it at 1.
- CW=4, 20 INF cycles: `icount_out` stops at 4'hF. `ctr_clr_in` asserted together with `il_in` gives 0. Reset asserted mid-run zeroes PC, IR and both counters immediately.
